// File: rtl/program_sequencer_if.sv
// Decoder/sequencer bundle: op, operands and fault clear in one direction;
// pc, stack status and fault status in the other.
interface program_sequencer_if #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic             clear_fault;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic             stack_empty;
  logic             stack_full;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output op, target, offset, clear_fault,
    input  pc, depth, stack_empty, stack_full, fault, fault_code
  );

  modport slave (
    input  op, target, offset, clear_fault,
    output pc, depth, stack_empty, stack_full, fault, fault_code
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with relative branch, call/return via a hardware LIFO,
// explicit hold and sticky fault reporting for stack errors and bad opcodes.
module program_sequencer #(
  parameter int               WIDTH        = 8,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_enable,
  program_sequencer_if.slave   bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HOLD   = 3'd5;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVER  = 2'b01;
  localparam logic [1:0] FC_UNDER = 2'b10;
  localparam logic [1:0] FC_ILLEG = 2'b11;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];

  logic             empty, full;
  logic             evt;
  logic [1:0]       evt_code;
  logic [IW-1:0]    push_idx, pop_idx;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == FULL);
  assign push_idx = IW'(depth_q);
  assign pop_idx  = IW'(depth_q - 1'b1);

  always_comb begin
    pc_d         = pc_q;
    depth_d      = depth_q;
    stack_d      = stack_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    evt          = 1'b0;
    evt_code     = FC_NONE;
    if (clk_enable) begin
      unique case (bus.op)
        OP_INC:    pc_d = pc_q + 1'b1;
        OP_JUMP:   pc_d = bus.target;
        OP_BRANCH: pc_d = pc_q + bus.offset;
        OP_CALL:
          if (full) begin
            evt      = 1'b1;
            evt_code = FC_OVER;
          end else begin
            stack_d[push_idx] = pc_q + 1'b1;
            depth_d           = depth_q + 1'b1;
            pc_d              = bus.target;
          end
        OP_RET:
          if (empty) begin
            evt      = 1'b1;
            evt_code = FC_UNDER;
          end else begin
            pc_d    = stack_q[pop_idx];
            depth_d = depth_q - 1'b1;
          end
        OP_HOLD: ;
        default: begin
          evt      = 1'b1;
          evt_code = FC_ILLEG;
        end
      endcase
      // A clear in the same cycle as a new event restarts the latch, so the new cause is recorded.
      if (evt) begin
        fault_d = 1'b1;
        if (!fault_q || bus.clear_fault) fault_code_d = evt_code;
      end else if (bus.clear_fault) begin
        fault_d      = 1'b0;
        fault_code_d = FC_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      depth_q      <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      depth_q      <= depth_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      stack_q      <= stack_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.depth       = depth_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: hand-computed pc, stack and fault values.
module tb_program_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  logic clk_enable;
  int   checks = 0;
  int   errors = 0;

  program_sequencer_if #(.WIDTH(8), .STACK_DEPTH(4)) bus ();

  program_sequencer #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the next rising edge.
  task automatic step(input logic [2:0] op, input logic [7:0] tgt = 8'h00,
                      input logic [7:0] off = 8'h00, input logic clr = 1'b0,
                      input logic en = 1'b1);
    @(negedge clk);
    bus.op          = op;
    bus.target      = tgt;
    bus.offset      = off;
    bus.clear_fault = clr;
    clk_enable      = en;
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic [7:0] pc, input logic [2:0] d,
                        input logic f, input logic [1:0] fc);
    chk({tag, ".pc"},    32'(bus.pc), 32'(pc));
    chk({tag, ".depth"}, 32'(bus.depth), 32'(d));
    chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(d == 3'd0));
    chk({tag, ".full"},  32'(bus.stack_full), 32'(d == 3'd4));
    chk({tag, ".fault"}, 32'(bus.fault), 32'(f));
    chk({tag, ".code"},  32'(bus.fault_code), 32'(fc));
  endtask

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HOLD = 3'd5;

  initial begin
    reset_n = 1'b0;
    clk_enable = 1'b1;
    bus.op = HOLD; bus.target = '0; bus.offset = '0; bus.clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    status("reset", 8'h00, 3'd0, 1'b0, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    repeat (3) step(INC);
    status("inc3", 8'h03, 3'd0, 1'b0, 2'b00);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1 chk("async_rst.pc", 32'(bus.pc), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;

    step(JMP, 8'hFE);
    chk("jump_fe", 32'(bus.pc), 32'hFE);
    step(INC);
    step(INC);
    chk("inc_wrap", 32'(bus.pc), 32'h00);
    step(JMP, 8'h10);
    step(BR, 8'h00, 8'hF0);
    chk("branch_neg", 32'(bus.pc), 32'h00);
    step(BR, 8'h00, 8'h05);
    chk("branch_pos", 32'(bus.pc), 32'h05);

    step(JMP, 8'h20);
    step(CALL, 8'h40);
    status("call1", 8'h40, 3'd1, 1'b0, 2'b00);
    step(CALL, 8'h60);
    status("call2", 8'h60, 3'd2, 1'b0, 2'b00);
    step(RET);
    status("ret1", 8'h41, 3'd1, 1'b0, 2'b00);
    step(RET);
    status("ret2", 8'h21, 3'd0, 1'b0, 2'b00);

    // Fill: pushes 22, 81, 82, 83
    step(CALL, 8'h80);
    step(CALL, 8'h81);
    step(CALL, 8'h82);
    step(CALL, 8'h83);
    status("fill", 8'h83, 3'd4, 1'b0, 2'b00);
    step(CALL, 8'h99);
    status("overflow", 8'h83, 3'd4, 1'b1, 2'b01);
    step(3'd7);
    status("illegal_after_ovf", 8'h83, 3'd4, 1'b1, 2'b01);

    step(RET);
    chk("pop4.pc", 32'(bus.pc), 32'h83);
    step(RET);
    chk("pop3.pc", 32'(bus.pc), 32'h82);
    step(RET);
    chk("pop2.pc", 32'(bus.pc), 32'h81);
    step(RET);
    status("pop1", 8'h22, 3'd0, 1'b1, 2'b01);

    step(HOLD, 8'h00, 8'h00, 1'b1);
    status("clear1", 8'h22, 3'd0, 1'b0, 2'b00);
    step(RET);
    status("underflow", 8'h22, 3'd0, 1'b1, 2'b10);
    step(HOLD, 8'h00, 8'h00, 1'b1);
    status("clear2", 8'h22, 3'd0, 1'b0, 2'b00);
    step(3'd6, 8'h00, 8'h00, 1'b1);
    status("clr_and_illegal", 8'h22, 3'd0, 1'b1, 2'b11);
    step(RET, 8'h00, 8'h00, 1'b1);
    status("clr_and_underflow", 8'h22, 3'd0, 1'b1, 2'b10);

    step(CALL, 8'h50);
    status("call_faulted", 8'h50, 3'd1, 1'b1, 2'b10);
    step(HOLD);
    status("hold", 8'h50, 3'd1, 1'b1, 2'b10);

    step(CALL, 8'h70, 8'h00, 1'b0, 1'b0);
    step(RET,  8'h00, 8'h00, 1'b0, 1'b0);
    step(INC,  8'h00, 8'h00, 1'b0, 1'b0);
    step(HOLD, 8'h00, 8'h00, 1'b1, 1'b0);
    step(3'd7, 8'h00, 8'h00, 1'b1, 1'b0);
    status("gated", 8'h50, 3'd1, 1'b1, 2'b10);

    step(RET);
    status("ret_after_gate", 8'h23, 3'd0, 1'b1, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the team's program counter.
- Adds four operations beyond increment and absolute load:
  - relative branch
  - subroutine call with a hardware return-address stack
  - return
  - explicit hold
- Reports stack errors and illegal opcodes through sticky fault status.
- Sits between the instruction decoder (which drives `op`, `target` and `offset`) and instruction memory (which consumes `pc`).

Parameters:
- WIDTH, 8: PC, target, offset and stack-entry width.
- STACK_DEPTH, 4: return-stack entries. Must be ≥ 1.
- RESET_VECTOR, 0: value loaded into `pc` on reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  when 0, all state holds and the op is ignored
- op  in  3  operation: 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6–7 illegal
- target  in  WIDTH  absolute destination for JUMP and CALL
- offset  in  WIDTH  two's-complement displacement for BRANCH
- clear_fault  in  1  synchronous clear of `fault` and `fault_code`; gated by `clk_enable`
- pc  out  WIDTH  current program counter
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_empty  out  1  `depth` == 0
- stack_full  out  1  `depth` == STACK_DEPTH
- fault  out  1  sticky error flag
- fault_code  out  2  cause of the first fault since the last clear: 01 overflow, 10 underflow, 11 illegal op, 00 none

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - `pc` = RESET_VECTOR, `depth` = 0
  - `stack_empty` = 1, `stack_full` = 0
  - `fault` = 0, `fault_code` = 00
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts any pending update immediately.
- All updates happen on the rising edge of `clk` with clk_enable = 1.
- Outputs are registered or derived from registers: one-cycle latency from op to new `pc`. No combinational path from inputs to outputs.
- Operations with clk_enable = 1:
  - INC: `pc` <= `pc` + 1, modulo 2^WIDTH (0xFF→0x00 for WIDTH = 8).
  - JUMP: `pc` <= `target`.
  - BRANCH: `pc` <= `pc` + `offset`, WIDTH-bit modulo add. The offset is sign-interpreted, with no overflow detection.
  - CALL, stack not full: push `pc` + 1 (modulo) to `stack[depth]`, `depth` += 1, `pc` <= `target`.
  - CALL, stack full: no push, `pc` holds, fault raised with code 01.
  - RET, stack not empty: `pc` <= `stack[depth-1]`, `depth` -= 1.
  - RET, stack empty: `pc` holds, fault raised with code 10.
  - HOLD: no state change.
  - Illegal op (6, 7): `pc` and stack hold, fault raised with code 11.
- Fault rules:
  - `fault` sets on any fault event and stays set until clear_fault = 1 (with clk_enable) or reset.
  - `fault_code` latches only the first event while `fault` = 0. Later events while `fault` = 1 leave the code unchanged.
  - clear_fault and a new fault event in the same cycle: the new fault wins, so `fault` = 1 and `fault_code` = new cause.
- With clk_enable = 0, nothing changes, including `fault` clearing.
- The stack is LIFO with a single push or pop per cycle; there is no simultaneous push and pop.
- `stack_full` and `stack_empty` are decoded from `depth` and update in the same edge as `depth`.
- The implementation must be legal for STACK_DEPTH = 1, where `depth` is 1 bit wide.

Test Plan:
- Reset then 3× INC (WIDTH = 8) -> `pc` = 0x03, `depth` = 0, `stack_empty` = 1, `fault` = 0. Assert reset_n low mid-cycle -> `pc` = 0x00 immediately, without waiting for a clock edge.
- Wrap and branch:
  - JUMP 0xFE, then INC ×2 -> `pc` = 0x00.
  - JUMP 0x10, then BRANCH offset 0xF0 -> `pc` = 0x00.
  - BRANCH offset 0x05 -> `pc` = 0x05.
- Nested calls:
  - From `pc` = 0x20: CALL 0x40 -> `pc` = 0x40, `depth` = 1.
  - CALL 0x60 -> `pc` = 0x60, `depth` = 2.
  - RET -> `pc` = 0x41; RET -> `pc` = 0x21, `depth` = 0, `stack_empty` = 1.
- Overflow:
  - 4× CALL -> `stack_full` = 1.
  - 5th CALL 0x99 -> `pc` unchanged, `depth` = 4, `fault` = 1, `fault_code` = 01.
  - Follow with an illegal op 7 -> `fault_code` stays 01.
- Underflow and clear:
  - RET with `depth` = 0 -> `pc` holds, `fault_code` = 10.
  - clear_fault -> `fault` = 0, `fault_code` = 00.
  - clear_fault together with op 6 -> `fault` = 1, `fault_code` = 11.
- Enable gating: clk_enable = 0 with CALL, RET, INC and clear_fault applied over several cycles -> `pc`, `depth` and `fault` all unchanged.
